// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side bridge: sram-like req/addr_ok/data_ok fetch port to in-order AXI4 single-beat reads.
// Optional macro INST_BRIDGE_RRESP_CHK_EN adds inst_sram_rerr (rresp[1] of the returned beat).

module inst_axi_rd_bridge_chk #(
  parameter logic [2:0] MAX_CNT = 3'd2
) (
  input logic        clk,
  input logic        reset,
  input logic [2:0]  cnt,
  input logic        arvalid,
  input logic        arready,
  input logic [31:0] araddr,
  input logic        r_fire,
  input logic        data_ok
);

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt <= MAX_CNT);

  a_ar_hold: assert property (@(posedge clk) disable iff (reset)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  a_dok_follows_r: assert property (@(posedge clk) disable iff (reset) r_fire |=> data_ok);

endmodule

module inst_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
`ifdef INST_BRIDGE_RRESP_CHK_EN
  ,
  output logic        inst_sram_rerr
`endif
);

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  ar_state_t  ar_state_r;
  logic [2:0] cnt_r;
  logic       can_accept_s;
  logic       r_fire_s;
  logic       unused_inputs_s;

  // Single ID and arlen=0 make rid and rlast carry no information here.
`ifdef INST_BRIDGE_RRESP_CHK_EN
  assign unused_inputs_s = ^{rid, rlast, rresp[0]};
`else
  assign unused_inputs_s = ^{rid, rlast, rresp};
`endif

  assign arid    = AXI_ID;
  assign arlen   = 8'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign can_accept_s      = (cnt_r < MAX_CNT);
  assign inst_sram_addr_ok = ~reset & (ar_state_r == AR_IDLE) & inst_sram_req
                             & ~inst_sram_wr & can_accept_s;
  assign rready            = (cnt_r != 3'd0);
  assign r_fire_s          = rvalid & rready;

  // AR channel FSM: capture the accepted address and hold it until the slave takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state_r <= AR_IDLE;
      arvalid    <= 1'b0;
      araddr     <= 32'd0;
    end else begin
      case (ar_state_r)
        AR_IDLE: begin
          if (inst_sram_addr_ok) begin
            araddr     <= inst_sram_addr;
            arvalid    <= 1'b1;
            ar_state_r <= AR_SEND;
          end else begin
            arvalid    <= 1'b0;
            ar_state_r <= AR_IDLE;
          end
        end
        AR_SEND: begin
          if (arready) begin
            arvalid    <= 1'b0;
            ar_state_r <= AR_IDLE;
          end else begin
            arvalid    <= 1'b1;
            ar_state_r <= AR_SEND;
          end
        end
        default: begin
          arvalid    <= 1'b0;
          ar_state_r <= AR_IDLE;
        end
      endcase
    end
  end

  // Outstanding counter: accepted-but-not-returned requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 3'd0;
    end else begin
      case ({inst_sram_addr_ok, r_fire_s})
        2'b10:   cnt_r <= cnt_r + 3'd1;
        2'b01:   cnt_r <= cnt_r - 3'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Response path: one data_ok pulse per R beat, rdata held until the next beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= 32'd0;
`ifdef INST_BRIDGE_RRESP_CHK_EN
      inst_sram_rerr    <= 1'b0;
`endif
    end else begin
      inst_sram_data_ok <= r_fire_s;
      if (r_fire_s) begin
        inst_sram_rdata <= rdata;
      end else begin
        inst_sram_rdata <= inst_sram_rdata;
      end
`ifdef INST_BRIDGE_RRESP_CHK_EN
      inst_sram_rerr    <= r_fire_s & rresp[1];
`endif
    end
  end

  inst_axi_rd_bridge_chk #(
    .MAX_CNT (MAX_CNT)
  ) u_chk (
    .clk     (clk),
    .reset   (reset),
    .cnt     (cnt_r),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .r_fire  (r_fire_s),
    .data_ok (inst_sram_data_ok)
  );

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench for inst_axi_rd_bridge: randomized IF requests and AXI slave, checked against a queue model.
`timescale 1ns/1ps

module tb_inst_axi_rd_bridge;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr;
  logic [31:0] addr;
  logic        addr_ok, data_ok;
  logic [31:0] sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
`ifdef INST_BRIDGE_RRESP_CHK_EN
  logic        rerr;
`endif

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAXO), .AXI_ID(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
`ifdef INST_BRIDGE_RRESP_CHK_EN
    .inst_sram_rerr(rerr),
`endif
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] ar_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] dok_log[$];
  logic [31:0] rq_addr[$];
  int          rq_t[$];
  int          cyc = 0;
  int          mcnt = 0;
  bit          ar_pend = 0, dok_due = 0, err_due = 0, after_rst = 0;
  bit          ar_low = 0, ar_rand = 0;
  int          fix_delay = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic logic [31:0] get_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  // AXI slave: in-order, one beat per AR, each beat delayed after its AR handshake
  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rid = 4'd0; rlast = 1'b1;
    forever begin
      @(negedge clk);
      if (ar_low) arready = 1'b0;
      else if (ar_rand) arready = ($urandom_range(0, 9) < 7);
      else arready = 1'b1;
      if (rq_addr.size() > 0 && rq_t[0] <= cyc) begin
        rvalid = 1'b1;
        rdata  = get_word(rq_addr[0]);
        rresp  = 2'($urandom_range(0, 3));
      end else begin
        rvalid = 1'b0;
        rdata  = $urandom;
        rresp  = 2'd0;
      end
      #1;
      if (reset) begin
        rq_addr.delete();
        rq_t.delete();
      end else begin
        if (rvalid && rready) begin
          void'(rq_addr.pop_front());
          void'(rq_t.pop_front());
        end
        if (arvalid && arready) begin
          rq_addr.push_back(araddr);
          rq_t.push_back(cyc + ((fix_delay > 0) ? fix_delay : int'($urandom_range(1, 6))));
        end
      end
      cyc++;
    end
  end

  // Monitor and reference model: every cycle view is what the next rising edge will see
  initial begin
    bit exp_aok, r_hs;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        chk("addr_ok_in_reset", {31'd0, addr_ok}, 32'd0);
        ar_q.delete(); exp_q.delete();
        mcnt = 0; ar_pend = 0; dok_due = 0; err_due = 0; after_rst = 1;
      end else begin
        if (after_rst) begin
          chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
          chk("rst_rready", {31'd0, rready}, 32'd0);
          chk("rst_data_ok", {31'd0, data_ok}, 32'd0);
          chk("rst_araddr", araddr, 32'd0);
          chk("rst_rdata", sram_rdata, 32'd0);
          after_rst = 0;
        end
        exp_aok = req && !wr && !ar_pend && (mcnt < MAXO);
        chk("addr_ok", {31'd0, addr_ok}, {31'd0, exp_aok});
        chk("arvalid", {31'd0, arvalid}, {31'd0, ar_pend});
        chk("rready", {31'd0, rready}, {31'd0, (mcnt != 0)});
        chk("data_ok", {31'd0, data_ok}, {31'd0, dok_due});
        if (data_ok && dok_due) begin
          dok_log.push_back(sram_rdata);
          if (exp_q.size() == 0) fail("scoreboard_empty");
          else chk("rdata", sram_rdata, exp_q.pop_front());
`ifdef INST_BRIDGE_RRESP_CHK_EN
          chk("rerr", {31'd0, rerr}, {31'd0, err_due});
`endif
        end
`ifdef INST_BRIDGE_RRESP_CHK_EN
        if (!data_ok) chk("rerr_idle", {31'd0, rerr}, 32'd0);
`endif
        if (ar_pend && ar_q.size() > 0) begin
          chk("araddr", araddr, ar_q[0]);
          if (arready) begin
            chk("ar_consts", {6'd0, arid, arlen, arsize, arburst, arlock, arcache, arprot},
                {6'd0, 4'd0, 8'd0, 3'b010, 2'b01, 2'b00, 4'd0, 3'd0});
            void'(ar_q.pop_front());
            ar_pend = 0;
          end
        end
        r_hs = rvalid && (mcnt != 0);
        if (exp_aok) begin
          ar_q.push_back(addr);
          exp_q.push_back(get_word(addr));
          ar_pend = 1;
          mcnt++;
        end
        if (r_hs) mcnt--;
        dok_due = r_hs;
        err_due = r_hs && rresp[1];
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic send_req(input logic [31:0] a);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      req = 1'b1; wr = 1'b0; addr = a;
      #1;
      ok = addr_ok;
    end
    if (!ok) fail("send_req");
  endtask

  task automatic drain(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      req = 1'b0; wr = 1'b0;
      #1;
      done = (exp_q.size() == 0) && (ar_q.size() == 0) && (mcnt == 0) && (rq_addr.size() == 0);
    end
    if (!done) fail(name);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    logic [31:0] rnd;
    reset = 1'b1; req = 1'b0; wr = 1'b0; addr = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(3);

    // Single fetch, minimum latency
    mem[32'h1C00_0000] = 32'h0280_0C0C;
    @(negedge clk); req = 1'b1; addr = 32'h1C00_0000;
    #1; chk("t1_addr_ok", {31'd0, addr_ok}, 32'd1);
    @(negedge clk); req = 1'b0;
    #1; chk("t1_arvalid", {31'd0, arvalid}, 32'd1);
    chk("t1_araddr", araddr, 32'h1C00_0000);
    got = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk); #1;
      if (data_ok) begin
        got = 1;
        chk("t1_latency", 32'(i + 1), 32'd3);
        chk("t1_rdata", sram_rdata, 32'h0280_0C0C);
      end
    end
    if (!got) fail("t1_data_ok");
    drain("t1_drain");

    // Continuous requests with slow R: outstanding limit
    fix_delay = 5;
    idle(2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); req = 1'b1; wr = 1'b0; addr = 32'h1C00_0100 + 32'(4 * i);
      #1; if (addr_ok) n++;
    end
    chk("t2_accepts", 32'(n), 32'd2);
    drain("t2_drain");

    // Ordered responses
    fix_delay = 1;
    mem[32'h1C00_0000] = 32'h1111_1111;
    mem[32'h1C00_0004] = 32'h2222_2222;
    idle(2);
    dok_log.delete();
    send_req(32'h1C00_0000);
    send_req(32'h1C00_0004);
    drain("t3_drain");
    chk("t3_count", 32'(dok_log.size()), 32'd2);
    if (dok_log.size() == 2) begin
      chk("t3_first", dok_log[0], 32'h1111_1111);
      chk("t3_second", dok_log[1], 32'h2222_2222);
    end

    // AR stall
    ar_low = 1;
    idle(2);
    send_req(32'h1C00_0200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); req = 1'b1; addr = 32'h1C00_0300;
      #1;
      chk("t4_arvalid", {31'd0, arvalid}, 32'd1);
      chk("t4_araddr", araddr, 32'h1C00_0200);
      chk("t4_no_addr_ok", {31'd0, addr_ok}, 32'd0);
    end
    @(negedge clk); ar_low = 0; req = 1'b0;
    drain("t4_drain");

    // Reset mid-operation
    ar_low = 1;
    idle(2);
    send_req(32'h1C00_0400);
    @(negedge clk); req = 1'b0;
    #1; chk("t5_pre_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; ar_low = 0;
    #1;
    chk("t5_arvalid", {31'd0, arvalid}, 32'd0);
    chk("t5_rready", {31'd0, rready}, 32'd0);
    send_req(32'h1C00_0404);
    @(negedge clk); req = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk); #1;
      if (data_ok) begin
        got = 1;
        chk("t5_rdata", sram_rdata, get_word(32'h1C00_0404));
      end
    end
    if (!got) fail("t5_data_ok");
    drain("t5_drain");

    // Randomized traffic
    fix_delay = 0;
    ar_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rnd  = $urandom;
      req  = ($urandom_range(0, 2) != 0);
      wr   = ($urandom_range(0, 9) == 0);
      addr = {16'h1C00, rnd[15:2], 2'b00};
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
